macro_io_sampler: RTL and testbench

MACRO_IO_SAMPLER -- requirements
Module: macro_io_sampler

---
 rtl/macro_io_pkg.sv | 33 +++
 rtl/macro_io_serializer.sv | 46 ++++
 rtl/macro_io_sampler.sv | 118 +++++++++++
 tb/tb_macro_io_sampler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macro_io_pkg.sv
// Shared field layout, state encoding and expected-pattern helper for the macro IO sampler.
package macro_io_pkg;

  localparam int EAST_W    = 14;
  localparam int WEST_W    = 14;
  localparam int NORTH_W   = 10;
  localparam int WORD_W    = EAST_W + WEST_W + NORTH_W;
  localparam int EAST_LSB  = 0;
  localparam int WEST_LSB  = EAST_W;
  localparam int NORTH_LSB = EAST_W + WEST_W;
  localparam int CNT_W     = $clog2(WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Tile k is expected to drive bit k of every field; the narrow north field limits this to k < 10.
  function automatic logic [WORD_W-1:0] expected_word(input int unsigned k);
    logic [WORD_W-1:0] w;
    w = '0;
    if (k < NORTH_W) begin
      w = (WORD_W'(1) << (NORTH_LSB + k)) |
          (WORD_W'(1) << (WEST_LSB + k))  |
          (WORD_W'(1) << (EAST_LSB + k));
    end
    return w;
  endfunction

endpackage

// File: rtl/macro_io_serializer.sv
// MSB-first serializer for one captured IO word with a valid/ready output stream.
module macro_io_serializer
  import macro_io_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_valid,
  output logic              last_accept
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;
  logic              accept;

  // Handshake: a bit transfers on a cycle with ser_valid=1 and ser_ready=1; while
  // ser_valid=1 and ser_ready=0 the word and counter hold, so ser_data stays stable.
  assign accept      = active_q & ser_ready;
  assign last_accept = accept & (cnt_q == '0);
  assign ser_valid   = active_q;
  assign ser_data    = active_q & shift_q[WORD_W-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      shift_q  <= load_data;
      cnt_q    <= CNT_W'(WORD_W - 1);
      active_q <= 1'b1;
    end else if (accept) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        shift_q <= {shift_q[WORD_W-2:0], 1'b0};
        cnt_q   <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/macro_io_sampler.sv
// Samples one macro tile's IO bus after a settle delay, compares it with the tile's
// expected pattern, streams the capture out serially and keeps pass/fail tallies.
module macro_io_sampler
  import macro_io_pkg::*;
#(
  parameter int N_MACROS = 4,
  parameter int SETTLE   = 2,
  localparam int SEL_W   = (N_MACROS > 1) ? $clog2(N_MACROS) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [SEL_W-1:0]           sel,
  input  logic [N_MACROS*WORD_W-1:0] io_o,
  input  logic [N_MACROS*WORD_W-1:0] io_oe,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [WORD_W-1:0]          mismatch,
  output logic                       ser_data,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic [7:0]                 pass_cnt,
  output logic [7:0]                 fail_cnt,
  output state_e                     state_dbg
);

  state_e            state_q, state_d;
  logic [3:0]        settle_q;
  logic [SEL_W-1:0]  sel_q;
  logic [WORD_W-1:0] tile_word;
  logic [WORD_W-1:0] mismatch_d;
  logic [WORD_W-1:0] mismatch_q;
  logic              pass_q;
  logic [7:0]        pass_cnt_q, fail_cnt_q;
  logic              load;
  logic              last_accept;

  // Undriven pins (oe=0) read as 0; an out-of-range tile index matches no tile and reads all-zero.
  always_comb begin
    tile_word = '0;
    for (int k = 0; k < N_MACROS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        tile_word = io_o[k*WORD_W +: WORD_W] & io_oe[k*WORD_W +: WORD_W];
      end
    end
  end

  assign mismatch_d = tile_word ^ expected_word(32'(sel_q));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_q == 4'(SETTLE - 1)) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT:   if (last_accept) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      sel_q      <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        sel_q    <= sel;
        settle_q <= '0;
      end else if (state_q == ST_SETTLE) begin
        settle_q <= settle_q + 1'b1;
      end
      if (state_q == ST_CAPTURE) begin
        mismatch_q <= mismatch_d;
        pass_q     <= (mismatch_d == '0);
      end
      // Tallies saturate so a long soak never wraps back to a misleading small count.
      if (state_q == ST_DONE) begin
        if (pass_q) begin
          if (pass_cnt_q != 8'hFF) pass_cnt_q <= pass_cnt_q + 1'b1;
        end else begin
          if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 1'b1;
        end
      end
    end
  end

  macro_io_serializer u_serializer (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load),
    .load_data   (tile_word),
    .ser_ready   (ser_ready),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .last_accept (last_accept)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign mismatch  = mismatch_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_macro_io_sampler.sv
// Randomized bench for macro_io_sampler: a behavioural model predicts each capture,
// compare result and tally; a serial scoreboard checks every transferred bit.
module tb_macro_io_sampler;
  import macro_io_pkg::*;

  // Five tiles so a 3-bit sel can carry the out-of-range index 5.
  localparam int N_MACROS = 5;
  localparam int SETTLE   = 2;
  localparam int SEL_W    = 3;
  localparam int IO_W     = N_MACROS * WORD_W;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [SEL_W-1:0]  sel;
  logic [IO_W-1:0]   io_o;
  logic [IO_W-1:0]   io_oe;
  logic              busy;
  logic              done;
  logic              pass;
  logic [WORD_W-1:0] mismatch;
  logic              ser_data;
  logic              ser_valid;
  logic              ser_ready;
  logic [7:0]        pass_cnt;
  logic [7:0]        fail_cnt;
  state_e            state_dbg;

  int n_checks;
  int n_errors;
  int m_pass_cnt;
  int m_fail_cnt;
  int done_seen;
  logic [0:0] exp_q[$];

  macro_io_sampler #(.N_MACROS(N_MACROS), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sel       (sel),
    .io_o      (io_o),
    .io_oe     (io_oe),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .mismatch  (mismatch),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial scoreboard and done-pulse counter
  always @(negedge clk) begin
    if (done) done_seen++;
    if (resetn && ser_valid) begin
      if (exp_q.size() == 0) begin
        chk("ser_extra_valid", 64'(ser_valid), 64'd0);
      end else begin
        chk("ser_bit", 64'(ser_data), 64'(exp_q[0]));
        if (ser_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Reference model
  function automatic logic [WORD_W-1:0] model_capture(input int s);
    if (s >= N_MACROS) return '0;
    return WORD_W'((io_o & io_oe) >> (s * WORD_W));
  endfunction

  function automatic logic [WORD_W-1:0] model_expected(input int k);
    logic [63:0] v;
    if (k >= 10) return '0;
    v = (64'd1 << (28 + k)) | (64'd1 << (14 + k)) | (64'd1 << k);
    return v[WORD_W-1:0];
  endfunction

  // Driver tasks
  task automatic randomize_io();
    for (int i = 0; i < IO_W; i++) begin
      io_o  = {io_o[IO_W-2:0], 1'($urandom_range(0, 1))};
      io_oe = {io_oe[IO_W-2:0], 1'($urandom_range(0, 1))};
    end
  endtask

  task automatic set_tile(input int s, input logic [WORD_W-1:0] o, input logic [WORD_W-1:0] oe);
    logic [IO_W-1:0] m;
    m     = IO_W'({WORD_W{1'b1}}) << (s * WORD_W);
    io_o  = (io_o & ~m) | (IO_W'(o) << (s * WORD_W));
    io_oe = (io_oe & ~m) | (IO_W'(oe) << (s * WORD_W));
  endtask

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall at bit 20,
  //       3 reset at bit 10, 4 extra start pulses in SETTLE and DONE
  task automatic run(input int s, input int mode);
    logic [WORD_W-1:0] cap;
    logic [WORD_W-1:0] mis;
    logic              pass_e;
    int                cyc;
    int                stall_left;
    int                busy_cycles;
    int                done_before;
    bit                stalled;
    bit                aborted;
    cap    = model_capture(s);
    mis    = cap ^ model_expected(s);
    pass_e = (mis == '0);
    for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(cap[b]);
    done_before = done_seen;
    stalled     = 0;
    stall_left  = 0;
    aborted     = 0;
    sel   = SEL_W'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sel   = SEL_W'($urandom_range(0, 7));
    cyc   = 1;
    while (!done && cyc < 400) begin
      if (mode == 4) start = (cyc == 1);
      if (mode == 1) begin
        ser_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (stall_left > 0 || (!stalled && exp_q.size() == 21 && ser_valid)) begin
          if (!stalled) stall_left = 5;
          stalled    = 1;
          ser_ready  = 1'b0;
          stall_left--;
          chk("stall_valid", 64'(ser_valid), 64'd1);
          chk("stall_data", 64'(ser_data), 64'(cap[20]));
        end else begin
          ser_ready = 1'b1;
        end
      end else begin
        ser_ready = 1'b1;
      end
      if (mode == 3 && state_dbg == ST_SHIFT && exp_q.size() == 11) begin
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end

    if (aborted) begin
      exp_q.delete();
      m_pass_cnt = 0;
      m_fail_cnt = 0;
      chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      chk("rst_ser_valid", 64'(ser_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
      chk("rst_fail_cnt", 64'(fail_cnt), 64'd0);
      chk("rst_mismatch", 64'(mismatch), 64'd0);
      busy_cycles = 0;
      repeat (SETTLE + 45) begin
        @(posedge clk); #1;
        if (busy) busy_cycles++;
      end
      chk("rst_no_done", 64'(done_seen - done_before), 64'd0);
      chk("rst_stays_idle", 64'(busy_cycles), 64'd0);
      return;
    end

    if (!done) begin
      chk("done_timeout", 64'(cyc), 64'd0);
      start = 1'b0;
      return;
    end
    if (mode == 0 || mode == 4) chk("latency", 64'(cyc), 64'(SETTLE + 40));
    if (mode == 2) chk("stall_applied", 64'(stalled), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_ser_valid", 64'(ser_valid), 64'd0);
    chk("pass", 64'(pass), 64'(pass_e));
    chk("mismatch", 64'(mismatch), 64'(mis));
    if (pass_e) begin
      if (m_pass_cnt < 255) m_pass_cnt++;
    end else begin
      if (m_fail_cnt < 255) m_fail_cnt++;
    end
    start = (mode == 4);
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_state", 64'(state_dbg), 64'(ST_IDLE));
    chk("pass_cnt", 64'(pass_cnt), 64'(m_pass_cnt));
    chk("fail_cnt", 64'(fail_cnt), 64'(m_fail_cnt));
    chk("bits_left", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_seen - done_before), 64'd1);
    if (mode == 4) begin
      busy_cycles = 0;
      repeat (SETTLE + 45) begin
        @(posedge clk); #1;
        if (busy) busy_cycles++;
      end
      chk("ignored_start_busy", 64'(busy_cycles), 64'd0);
      chk("ignored_start_done", 64'(done_seen - done_before), 64'd1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_pass_cnt = 0;
    m_fail_cnt = 0;
    done_seen  = 0;
    resetn     = 1'b0;
    start      = 1'b0;
    sel        = '0;
    ser_ready  = 1'b1;
    io_o       = '0;
    io_oe      = '0;
    randomize_io();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_pass", 64'(pass), 64'd0);
    chk("reset_ser_valid", 64'(ser_valid), 64'd0);
    chk("reset_ser_data", 64'(ser_data), 64'd0);
    chk("reset_mismatch", 64'(mismatch), 64'd0);
    chk("reset_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("reset_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Tile 0 drives its own pattern with every pin enabled
    set_tile(0, 38'h0010004001, {WORD_W{1'b1}});
    run(0, 0);
    chk("t0_pass", 64'(pass), 64'd1);
    chk("t0_pass_cnt", 64'(pass_cnt), 64'd1);

    // Tile 3 with east pin 3 not driven
    set_tile(3, model_expected(3), {WORD_W{1'b1}} ^ 38'h8);
    run(3, 0);
    chk("t3_mismatch", 64'(mismatch), 64'h8);
    chk("t3_fail_cnt", 64'(fail_cnt), 64'd1);

    // Back-pressure stall at bit 20
    randomize_io();
    run($urandom_range(0, N_MACROS - 1), 2);

    // Reset in the middle of shifting
    randomize_io();
    run($urandom_range(0, N_MACROS - 1), 3);

    // Out-of-range tile with ignored start pulses
    randomize_io();
    run(5, 4);
    chk("oor_pass", 64'(pass), 64'd0);

    // Random traffic, about half of it arranged to pass
    for (int r = 0; r < 20; r++) begin
      int s;
      randomize_io();
      s = $urandom_range(0, 7);
      if (s < N_MACROS && $urandom_range(0, 1) == 1) set_tile(s, model_expected(s), {WORD_W{1'b1}});
      run(s, 1);
    end

    // Saturation of the pass tally
    set_tile(0, model_expected(0), {WORD_W{1'b1}});
    for (int r = 0; r < 258; r++) run(0, 0);
    chk("pass_cnt_saturated", 64'(pass_cnt), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
